// File: rtl/pack_nonzero_if.sv
// Handshake and data bundle between the mask-update stage, pack_nonzero and the
// sparse operand loader that consumes the packed vector.
interface pack_nonzero_if #(
  parameter int unsigned IL     = 8,
  parameter int unsigned FL     = 12,
  parameter int unsigned length = 32
);
  localparam int unsigned W  = IL + FL;
  localparam int unsigned NV = 16;

  logic signed [W-1:0]   out [NV];
  logic [length-1:0]     i_mask;
  logic                  input_ready;
  logic                  output_taken;

  logic signed [W-1:0]   packed_vals [NV];
  logic [4:0]            count;
  logic                  mismatch;
  logic [1:0]            state;

  // Upstream producer / consumer side
  modport master (
    output out, i_mask, input_ready, output_taken,
    input  packed_vals, count, mismatch, state
  );

  // Packing engine side
  modport slave (
    input  out, i_mask, input_ready, output_taken,
    output packed_vals, count, mismatch, state
  );
endinterface

// File: rtl/pack_nonzero.sv
// Compacts the nonzero entries of 16 fixed-point layer outputs into the low slots
// of a result vector, one source slot per cycle, and cross-checks against the mask.
module pack_nonzero #(
  parameter int unsigned IL     = 8,
  parameter int unsigned FL     = 12,
  parameter int unsigned length = 32
) (
  input  logic          clk,
  input  logic          reset,
  pack_nonzero_if.slave bus
);
  localparam int unsigned W  = IL + FL;
  localparam int unsigned NV = 16;
  localparam int unsigned PW = $clog2(length) + 1;
  localparam int unsigned CW = (PW > 5) ? PW : 5;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t              state_q;
  logic signed [W-1:0] reg_out [NV];
  logic [length-1:0]   reg_mask;
  logic [3:0]          r_ptr;
  logic [4:0]          w_ptr;
  logic signed [W-1:0] packed_q [NV];
  logic [4:0]          count_q;
  logic                mismatch_q;

  logic [PW-1:0]       mask_pop_c;
  logic                cur_nz_c;
  logic [4:0]          w_next_c;

  // Population count of the latched mask
  always_comb begin
    mask_pop_c = '0;
    for (int i = 0; i < int'(length); i++) begin
      mask_pop_c = mask_pop_c + PW'(reg_mask[i]);
    end
  end

  // Zero test covers the full word, so any negative value counts as nonzero
  always_comb begin
    cur_nz_c = |reg_out[r_ptr];
    w_next_c = w_ptr + 5'(cur_nz_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      reg_mask   <= '0;
      r_ptr      <= '0;
      w_ptr      <= '0;
      count_q    <= '0;
      mismatch_q <= 1'b0;
      for (int i = 0; i < int'(NV); i++) begin
        reg_out[i]  <= '0;
        packed_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.input_ready) begin
            for (int i = 0; i < int'(NV); i++) begin
              reg_out[i]  <= bus.out[i];
              packed_q[i] <= '0;
            end
            reg_mask   <= bus.i_mask;
            r_ptr      <= '0;
            w_ptr      <= '0;
            count_q    <= '0;
            mismatch_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          // w_ptr never exceeds 15 while a write is still possible
          if (cur_nz_c) begin
            packed_q[w_ptr[3:0]] <= reg_out[r_ptr];
          end
          w_ptr <= w_next_c;
          r_ptr <= r_ptr + 4'd1;
          if (r_ptr == 4'd15) begin
            count_q    <= w_next_c;
            mismatch_q <= (CW'(mask_pop_c) != CW'(w_next_c));
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (bus.output_taken) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.packed_vals = packed_q;
  assign bus.count       = count_q;
  assign bus.mismatch    = mismatch_q;
  assign bus.state       = 2'(state_q);
endmodule

// File: tb/tb_pack_nonzero.sv
// Self-checking bench for pack_nonzero: directed cases plus randomized jobs
// compared against a queue-based compaction model.
module tb_pack_nonzero;
  localparam int unsigned W = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pack_nonzero_if bus ();
  pack_nonzero dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [W-1:0] stim [16];
  logic [31:0]         stim_mask;
  logic signed [W-1:0] exp_pk [16];
  int                  exp_cnt;
  logic                exp_mm;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: walk the inputs in order, keep the nonzero ones
  task automatic build_model();
    logic signed [W-1:0] q[$];
    q = {};
    foreach (stim[i]) if (stim[i] != 0) q.push_back(stim[i]);
    for (int i = 0; i < 16; i++) exp_pk[i] = (i < q.size()) ? q[i] : '0;
    exp_cnt = q.size();
    exp_mm  = ($countones(stim_mask) != exp_cnt);
  endtask

  task automatic drive_stim();
    for (int i = 0; i < 16; i++) bus.out[i] = stim[i];
    bus.i_mask = stim_mask;
  endtask

  task automatic check_results(input string name);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_slot%0d", name, i), 64'(W'(bus.packed_vals[i])), 64'(W'(exp_pk[i])));
    check({name, "_count"}, 64'(bus.count), 64'(exp_cnt));
    check({name, "_mismatch"}, 64'(bus.mismatch), 64'(exp_mm));
    check({name, "_state"}, 64'(bus.state), 64'(2'b10));
  endtask

  task automatic run_job(input bit disturb, input string name);
    int n;
    build_model();
    @(negedge clk);
    drive_stim();
    bus.input_ready = 1'b1;
    @(posedge clk); #1;
    bus.input_ready = 1'b0;
    check({name, "_accept"}, 64'(bus.state), 64'(2'b01));
    n = 0;
    while (bus.state != 2'b10 && n < 40) begin
      if (disturb && n == 4) begin
        bus.input_ready  = 1'b1;
        bus.output_taken = 1'b1;
        for (int i = 0; i < 16; i++) bus.out[i] = W'($urandom);
        bus.i_mask = $urandom;
      end else begin
        bus.input_ready  = 1'b0;
        bus.output_taken = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.input_ready  = 1'b0;
    bus.output_taken = 1'b0;
    check({name, "_busy_len"}, 64'(n), 64'(16));
    check_results(name);
  endtask

  task automatic release_job(input string name);
    @(negedge clk);
    bus.output_taken = 1'b1;
    @(posedge clk); #1;
    bus.output_taken = 1'b0;
    check({name, "_release"}, 64'(bus.state), 64'(2'b00));
    check({name, "_idle_count"}, 64'(bus.count), 64'(exp_cnt));
  endtask

  initial begin
    reset            = 1'b1;
    bus.input_ready  = 1'b0;
    bus.output_taken = 1'b0;
    for (int i = 0; i < 16; i++) stim[i] = '0;
    stim_mask = '0;
    drive_stim();
    repeat (2) @(negedge clk);
    check("rst_state", 64'(bus.state), 64'(2'b00));
    check("rst_count", 64'(bus.count), 64'(0));
    check("rst_mismatch", 64'(bus.mismatch), 64'(0));
    for (int i = 0; i < 16; i++) check($sformatf("rst_slot%0d", i), 64'(W'(bus.packed_vals[i])), 64'(0));
    reset = 1'b0;

    // All nonzero
    for (int i = 0; i < 16; i++) stim[i] = W'(i + 1);
    stim_mask = 32'h0000_FFFF;
    run_job(1'b0, "dense");
    release_job("dense");

    // Sparse with a negative value
    for (int i = 0; i < 16; i++) stim[i] = '0;
    stim[3] = 20'hFFFFB; stim[9] = 20'd7; stim[15] = 20'd1;
    stim_mask = 32'h0000_0007;
    run_job(1'b0, "sparse");

    // Hold in DONE while the other inputs wiggle
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.input_ready = c[0];
      for (int i = 0; i < 16; i++) bus.out[i] = W'($urandom);
      @(posedge clk); #1;
      check($sformatf("hold%0d_state", c), 64'(bus.state), 64'(2'b10));
      check($sformatf("hold%0d_count", c), 64'(bus.count), 64'(exp_cnt));
      check($sformatf("hold%0d_slot0", c), 64'(W'(bus.packed_vals[0])), 64'(W'(exp_pk[0])));
    end
    bus.input_ready = 1'b0;
    release_job("sparse");

    // All zero, mask disagrees
    for (int i = 0; i < 16; i++) stim[i] = '0;
    stim_mask = 32'h0000_0001;
    run_job(1'b0, "zeros");
    release_job("zeros");

    // output_taken in IDLE is ignored
    @(negedge clk);
    bus.output_taken = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.output_taken = 1'b0;
    check("idle_taken_state", 64'(bus.state), 64'(2'b00));

    // Controls pulsed during BUSY are ignored
    for (int i = 0; i < 16; i++) stim[i] = (i % 3 == 0) ? W'(-(i + 2)) : '0;
    stim_mask = 32'h8000_0003;
    run_job(1'b1, "ignore");
    release_job("ignore");

    // Reset in the middle of BUSY, checked before any further clock edge
    for (int i = 0; i < 16; i++) stim[i] = W'(i + 100);
    stim_mask = 32'hFFFF_0000;
    @(negedge clk);
    drive_stim();
    bus.input_ready = 1'b1;
    @(posedge clk); #1;
    bus.input_ready = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_state", 64'(bus.state), 64'(2'b00));
    check("midrst_count", 64'(bus.count), 64'(0));
    check("midrst_mismatch", 64'(bus.mismatch), 64'(0));
    for (int i = 0; i < 16; i++) check($sformatf("midrst_slot%0d", i), 64'(W'(bus.packed_vals[i])), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_state", 64'(bus.state), 64'(2'b00));

    // Randomized jobs
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 16; i++) stim[i] = ($urandom_range(0, 1) == 1) ? W'($urandom) : '0;
      build_model();
      if ($urandom_range(0, 1) == 1) stim_mask = (exp_cnt == 0) ? 32'h0 : (32'hFFFF_FFFF >> (32 - exp_cnt));
      else stim_mask = $urandom;
      run_job(t[2:0] == 3'd5, $sformatf("rnd%0d", t));
      release_job($sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pack_nonzero.md
# pack_nonzero

Downstream stage of the mask-update step. It takes the same 16 signed fixed-point layer outputs whose zero pattern updates the sparsity mask, and compacts them: nonzero values are packed, in original order, into the low slots of an output vector. It reports how many values survived and flags when that count disagrees with the population count of the updated mask. The next layer's sparse operand loader consumes the packed vector and count.

## Interface
Parameters:
- IL, 8, integer bits of fixed-point value
- FL, 12, fractional bits of fixed-point value
- length, 32, mask width

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all registers immediately
- out  input  signed [IL+FL-1:0] x16  dense layer outputs, sampled on accept
- i_mask  input  [length-1:0]  updated mask, sampled on accept
- input_ready  input  1  upstream has valid out/i_mask
- output_taken  input  1  consumer has taken the result
- packed  output  signed [IL+FL-1:0] x16  compacted nonzero values; slots >= count are 0
- count  output  [4:0]  number of nonzero values, 0..16
- mismatch  output  1  popcount(latched i_mask) != count; meaningful only in DONE
- state  output  [1:0]  00 IDLE, 01 BUSY, 10 DONE

## Operation
- Internal registers: reg_out[15:0], reg_mask, r_ptr[3:0], w_ptr[4:0], packed[15:0], count.
- IDLE (00): if input_ready=1, latch out into reg_out and i_mask into reg_mask, clear packed to all zeros, clear r_ptr, w_ptr, and count, then go to BUSY. input_ready=0 keeps the block in IDLE.
- BUSY (01): each cycle examines reg_out[r_ptr].
  - If the value is nonzero (any bit set), write it to packed[w_ptr] and increment w_ptr.
  - r_ptr increments every cycle.
  - When r_ptr=15 is processed, go to DONE and set count equal to the final w_ptr.
  - The zero test is on the full IL+FL-bit word. Negative values are nonzero.
- DONE (10): packed, count, and mismatch hold stable. If output_taken=1, go to IDLE. packed and count keep their values in IDLE until the next accept.
- input_ready is ignored outside IDLE. output_taken is ignored outside DONE.
- A simultaneous output_taken in DONE and input_ready does not accept a new input in the same cycle. The new input is accepted from IDLE on a later edge.
- Order preservation: packed[k] is the k-th nonzero of out[0..15] in ascending index order.
- mismatch = (popcount(reg_mask) != count). The popcount result is at least clog2(length)+1 bits wide and is compared zero-extended against count.
- Only 16 values are ever packed. w_ptr cannot exceed 16, so there is no overflow.

## Timing
- Reset (asynchronous, any time, including mid-BUSY) forces immediately:
  - state=00, packed all 0, count=0, mismatch=0;
  - r_ptr=0, w_ptr=0, reg_out and reg_mask cleared.
  - The in-flight job is discarded.
- Accept edge A: the first edge with state=00 and input_ready=1. state reads 01 after A.
- BUSY lasts exactly 16 cycles, independent of data. state reads 10 after edge A+16.
- packed, count, and mismatch are valid from the first DONE cycle and stay valid until the next accept edge.
- Release: the edge in DONE with output_taken=1 moves the block to IDLE. The earliest next accept is the following edge, so back-to-back throughput is 1 job per 18 cycles minimum.
- No combinational path from the inputs to any output.

## Test plan
- Reset mid-BUSY: assert reset at BUSY cycle 7. state=00, count=0, and all packed slots are 0 in the same cycle (asynchronous), with no clock edge needed.
- All nonzero: out[i]=i+1, i_mask=32'h0000FFFF. After 16 BUSY cycles, packed[i]=i+1, count=16, mismatch=0.
- Sparse with negatives: out[3]=-5 (20'hFFFFB), out[9]=7, out[15]=1, all others 0, i_mask with 3 bits set. Result: packed[0..2]=-5,7,1, packed[3..15]=0, count=3, mismatch=0.
- All zero with a nonzero mask: out all 0, i_mask=32'h00000001. Result: count=0, packed all 0, mismatch=1.
- Handshake holds: stay in DONE 5 cycles with output_taken=0 while out and input_ready toggle. Outputs are unchanged. output_taken=1 returns the block to IDLE. A new input_ready accepted on the next edge clears packed and produces a fresh result 16 cycles later.
- Ignored controls: pulse output_taken during IDLE and BUSY, and input_ready during BUSY. There is no state change and no relatch, and the BUSY length stays 16 cycles.
